// File: rtl/rpn_pkg.sv
// rpn_pkg: opcode and state types shared by the RPN evaluator and its ALU
package rpn_pkg;

    localparam int RPN_WIDTH = 8;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_END
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE,
        POP_B,
        POP_A,
        EXEC,
        POP_R,
        CHK,
        ERR,
        FLUSH
    } state_t;

endpackage

// File: rtl/rpn_alu.sv
// rpn_alu: unsigned modulo-2^WIDTH arithmetic on a (below top) and b (top of stack)
module rpn_alu
    import rpn_pkg::*;
#(
    parameter int WIDTH = RPN_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  opcode_t          op,
    output logic [WIDTH-1:0] y
);

    always_comb y = op == OP_ADD ? a + b :
                    op == OP_SUB ? a - b :
                    op == OP_MUL ? a * b : a;

endmodule

// File: rtl/rpn_eval.sv
// rpn_eval: reverse-Polish evaluator driving an external LIFO stack
module rpn_eval
    import rpn_pkg::*;
#(
    parameter int WIDTH = RPN_WIDTH,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             tok_valid,
    output logic             tok_ready,
    input  logic             tok_is_op,
    input  logic [WIDTH-1:0] tok_data,
    input  logic             clr,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [WIDTH-1:0] stk_data_in,
    input  logic [WIDTH-1:0] stk_data_out,
    input  logic             stk_full,
    input  logic             stk_empty,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             err
);

    localparam int OW = $clog2(DEPTH + 1);

    state_t           state, state_nx;
    opcode_t          op_q, tok_op;
    logic [WIDTH-1:0] b_q, alu_y;
    logic             accept;

    assign tok_op = opcode_t'(tok_data[1:0]);
    assign accept = tok_valid && tok_ready;
    assign err    = state == ERR || state == FLUSH;

    rpn_alu #(.WIDTH(WIDTH)) u_alu (
        .a  (stk_data_out),
        .b  (b_q),
        .op (op_q),
        .y  (alu_y)
    );

    always_comb begin
        state_nx    = state;
        tok_ready   = 1'b0;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        stk_data_in = '0;
        unique case (state)
            IDLE: begin
                tok_ready = 1'b1;
                if (tok_valid && !tok_is_op) begin
                    stk_push    = !stk_full;
                    stk_data_in = stk_full ? '0 : tok_data;
                    state_nx    = stk_full ? ERR : IDLE;
                end else if (tok_valid) begin
                    state_nx = tok_op == OP_END ? POP_R : POP_B;
                end
            end
            POP_B: begin
                stk_pop  = !stk_empty;
                state_nx = stk_empty ? ERR : POP_A;
            end
            POP_A: begin
                stk_pop  = !stk_empty;
                state_nx = stk_empty ? ERR : EXEC;
            end
            EXEC: begin
                stk_push    = 1'b1;
                stk_data_in = alu_y;
                state_nx    = IDLE;
            end
            POP_R: begin
                stk_pop  = !stk_empty;
                state_nx = stk_empty ? ERR : CHK;
            end
            CHK:     state_nx = stk_empty ? IDLE : ERR;
            ERR:     state_nx = clr ? FLUSH : ERR;
            FLUSH: begin
                stk_pop  = !stk_empty;
                state_nx = stk_empty ? IDLE : FLUSH;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            op_q      <= OP_ADD;
            b_q       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            state     <= state_nx;
            res_valid <= state == CHK && stk_empty;
            if (accept && tok_is_op)
                op_q <= tok_op;
            if (state == POP_A)
                b_q <= stk_data_out;
            if (state == CHK && stk_empty)
                res_data <= stk_data_out;
        end
    end

    // shadow occupancy of the attached stack, only observed by the checks below
    logic [OW-1:0] occ;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            occ <= '0;
        else
            occ <= stk_push ? occ + OW'(1) : stk_pop ? occ - OW'(1) : occ;
    end

    a_no_push_pop: assert property (@(posedge clk) disable iff (!rstn) !(stk_push && stk_pop));
    a_no_push_full: assert property (@(posedge clk) disable iff (!rstn) !(stk_push && stk_full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rstn) !(stk_pop && stk_empty));
    a_occ_range: assert property (@(posedge clk) disable iff (!rstn) occ <= OW'(DEPTH));
    a_occ_flags: assert property (@(posedge clk) disable iff (!rstn)
        (stk_empty == (occ == '0)) && (stk_full == (occ == OW'(DEPTH))));

endmodule

// File: tb/tb_rpn_eval.sv
// tb_rpn_eval: directed bench for rpn_eval with a behavioural LIFO attached
module tb_rpn_eval;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             tok_valid = 1'b0;
    logic             tok_is_op = 1'b0;
    logic             clr = 1'b0;
    logic [WIDTH-1:0] tok_data = '0;
    logic             tok_ready, stk_push, stk_pop, stk_full, stk_empty, res_valid, err;
    logic [WIDTH-1:0] stk_data_in, stk_data_out, res_data;
    logic [WIDTH-1:0] mem [DEPTH];
    int               sp;
    int               n_assert = 0;
    int               n_fail = 0;
    int               push_cnt = 0;
    int               pop_cnt = 0;
    int               p0;

    always #5 clk = ~clk;

    rpn_eval #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .tok_valid    (tok_valid),
        .tok_ready    (tok_ready),
        .tok_is_op    (tok_is_op),
        .tok_data     (tok_data),
        .clr          (clr),
        .stk_push     (stk_push),
        .stk_pop      (stk_pop),
        .stk_data_in  (stk_data_in),
        .stk_data_out (stk_data_out),
        .stk_full     (stk_full),
        .stk_empty    (stk_empty),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .err          (err)
    );

    assign stk_full  = sp == DEPTH;
    assign stk_empty = sp == 0;

    // attached stack shares rstn with the evaluator
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sp           <= 0;
            stk_data_out <= '0;
        end else if (stk_push && !stk_full) begin
            mem[sp] <= stk_data_in;
            sp      <= sp + 1;
        end else if (stk_pop && !stk_empty) begin
            stk_data_out <= mem[sp-1];
            sp           <= sp - 1;
        end
    end

    always @(posedge clk) begin
        if (stk_push) push_cnt <= push_cnt + 1;
        if (stk_pop) pop_cnt <= pop_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tok(input logic op, input logic [WIDTH-1:0] d);
        int n = 0;
        while (!tok_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("tok_ready_wait", 32'(tok_ready), 1);
        tok_valid = 1'b1;
        tok_is_op = op;
        tok_data  = d;
        @(negedge clk);
        tok_valid = 1'b0;
        tok_is_op = 1'b0;
        tok_data  = '0;
    endtask

    task automatic end_expr(input logic [WIDTH-1:0] exp);
        tok(1'b1, 8'd3);
        check("res_valid_pop_r", 32'(res_valid), 0);
        @(negedge clk);
        check("res_valid_chk", 32'(res_valid), 0);
        @(negedge clk);
        check("res_valid", 32'(res_valid), 1);
        check("res_data", 32'(res_data), 32'(exp));
        check("err_after_result", 32'(err), 0);
        check("stack_empty_after_result", sp, 0);
        @(negedge clk);
        check("res_valid_pulse_end", 32'(res_valid), 0);
    endtask

    task automatic flush();
        int n = 0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        while (err && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("flush_err_clear", 32'(err), 0);
        check("flush_ready", 32'(tok_ready), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_push", 32'(stk_push), 0);
        check("rst_pop", 32'(stk_pop), 0);
        check("rst_data_in", 32'(stk_data_in), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_res_data", 32'(res_data), 0);
        check("rst_err", 32'(err), 0);
        rstn = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(tok_ready), 1);

        // 3 4 ADD END with cycle-level checks of the operator sequence
        tok(1'b0, 8'd3);
        tok(1'b0, 8'd4);
        check("two_pushed", sp, 2);
        tok(1'b1, 8'd0);
        check("add_pop_b", 32'(stk_pop), 1);
        check("add_busy", 32'(tok_ready), 0);
        @(negedge clk);
        check("add_pop_a", 32'(stk_pop), 1);
        @(negedge clk);
        check("add_exec_push", 32'(stk_push), 1);
        check("add_exec_data", 32'(stk_data_in), 7);
        @(negedge clk);
        check("add_ready_again", 32'(tok_ready), 1);
        check("add_one_left", sp, 1);
        end_expr(8'd7);

        // 10 3 SUB 2 MUL END, then 3 5 SUB END wraps
        tok(1'b0, 8'd10);
        tok(1'b0, 8'd3);
        tok(1'b1, 8'd1);
        tok(1'b0, 8'd2);
        tok(1'b1, 8'd2);
        end_expr(8'd14);
        tok(1'b0, 8'd3);
        tok(1'b0, 8'd5);
        tok(1'b1, 8'd1);
        end_expr(8'd254);

        // modulo wrap on MUL and ADD
        tok(1'b0, 8'd16);
        tok(1'b0, 8'd16);
        tok(1'b1, 8'd2);
        end_expr(8'd0);
        tok(1'b0, 8'd200);
        tok(1'b0, 8'd100);
        tok(1'b1, 8'd0);
        end_expr(8'd44);

        // overflow: ninth operand into a full stack
        for (int i = 1; i <= DEPTH; i++) tok(1'b0, 8'(i));
        check("full_sp", sp, DEPTH);
        check("full_flag", 32'(stk_full), 1);
        tok_valid = 1'b1;
        tok_data  = 8'd99;
        #1;
        check("ovf_no_push", 32'(stk_push), 0);
        @(negedge clk);
        tok_valid = 1'b0;
        tok_data  = '0;
        check("ovf_err", 32'(err), 1);
        check("ovf_not_ready", 32'(tok_ready), 0);
        check("ovf_sp", sp, DEPTH);
        @(negedge clk);
        check("ovf_err_sticky", 32'(err), 1);
        p0 = pop_cnt;
        flush();
        check("ovf_flush_pops", pop_cnt - p0, DEPTH);
        check("ovf_flush_empty", sp, 0);

        // underflow: 5 ADD errs at POP_A after one pop
        tok(1'b0, 8'd5);
        p0 = pop_cnt;
        tok(1'b1, 8'd0);
        check("unf_pop_b_err", 32'(err), 0);
        @(negedge clk);
        check("unf_pop_a_err", 32'(err), 0);
        @(negedge clk);
        check("unf_err", 32'(err), 1);
        check("unf_one_pop", pop_cnt - p0, 1);
        flush();

        // leftover operand: 1 2 END errs from CHK without a result
        tok(1'b0, 8'd1);
        tok(1'b0, 8'd2);
        tok(1'b1, 8'd3);
        check("left_res_pop_r", 32'(res_valid), 0);
        @(negedge clk);
        check("left_res_chk", 32'(res_valid), 0);
        check("left_err_chk", 32'(err), 0);
        @(negedge clk);
        check("left_err", 32'(err), 1);
        check("left_res_valid", 32'(res_valid), 0);
        check("left_sp", sp, 1);
        check("left_res_data_held", 32'(res_data), 44);
        flush();
        check("left_flush_empty", sp, 0);

        // reset while in EXEC
        tok(1'b0, 8'd3);
        tok(1'b0, 8'd4);
        tok(1'b1, 8'd2);
        @(negedge clk);
        @(negedge clk);
        check("mul_exec_push", 32'(stk_push), 1);
        check("mul_exec_data", 32'(stk_data_in), 12);
        p0 = push_cnt;
        rstn = 1'b0;
        #1;
        check("mid_rst_push", 32'(stk_push), 0);
        check("mid_rst_pop", 32'(stk_pop), 0);
        check("mid_rst_data_in", 32'(stk_data_in), 0);
        check("mid_rst_ready", 32'(tok_ready), 1);
        check("mid_rst_err", 32'(err), 0);
        check("mid_rst_res_valid", 32'(res_valid), 0);
        check("mid_rst_res_data", 32'(res_data), 0);
        repeat (2) @(negedge clk);
        check("mid_rst_no_push", push_cnt - p0, 0);
        rstn = 1'b1;
        @(negedge clk);
        tok(1'b0, 8'd7);
        end_expr(8'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rpn_eval.md
# rpn_eval

- Evaluates a reverse-Polish token stream (operands and operators).
- Acts as the initiator on the LIFO stack's push/pop/data_out/full/empty interface: it drives the stack, it does not contain one.
- Sits between a token source and one instance of the stack block. It returns one WIDTH-bit result per expression, or raises a sticky error that is recovered by a flush.

## Interface
- WIDTH, default 8: operand, result and stack data width; must equal the stack's data width.
- DEPTH, default 8: depth of the attached stack. Used only by assertions; overflow is detected from stk_full.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset: asynchronous, active-low.
- tok_valid  in  1  token present.
- tok_ready  out  1  token accepted when tok_valid && tok_ready.
- tok_is_op  in  1  1 = operator, 0 = operand.
- tok_data  in  WIDTH  operand value; if tok_is_op, bits[1:0] = opcode.
- clr  in  1  leave the error state and flush the stack.
- stk_push  out  1  push request.
- stk_pop  out  1  pop request.
- stk_data_in  out  WIDTH  push data.
- stk_data_out  in  WIDTH  popped value, valid the cycle after the pop edge.
- stk_full  in  1  stack full.
- stk_empty  in  1  stack empty.
- res_valid  out  1  one-cycle result pulse.
- res_data  out  WIDTH  last result, held until the next one.
- err  out  1  sticky error flag.

## Operation
Opcodes:
- 00 ADD: a+b.
- 01 SUB: a−b.
- 10 MUL: low WIDTH bits of a*b.
- 11 END: emit the result.

Operand order and arithmetic:
- b is the top of stack; a is the entry below it.
- All arithmetic is unsigned, modulo 2^WIDTH; there is no overflow flag.

States: IDLE, POP_B, POP_A, EXEC, POP_R, CHK, ERR, FLUSH.
- **IDLE**: tok_ready=1.
  - Operand with !stk_full: stk_push=1 and stk_data_in=tok_data in the same cycle (combinational); stay in IDLE.
  - Operand with stk_full: no push; go to ERR.
  - ADD/SUB/MUL: go to POP_B.
  - END: go to POP_R.
- **POP_B**:
  - stk_empty: go to ERR, no pop.
  - Otherwise: stk_pop=1, go to POP_A.
- **POP_A**:
  - Register b=stk_data_out.
  - stk_empty: go to ERR.
  - Otherwise: stk_pop=1, go to EXEC.
- **EXEC**: stk_push=1 with stk_data_in=op(stk_data_out, b); go to IDLE. The stack cannot be full here.
- **POP_R**:
  - stk_empty: go to ERR.
  - Otherwise: stk_pop=1, go to CHK.
- **CHK**:
  - stk_empty: res_data<=stk_data_out, res_valid=1, go to IDLE.
  - Otherwise: go to ERR (expression left extra operands).
- **ERR**:
  - err=1, tok_ready=0, no stack activity.
  - clr=1: go to FLUSH.
- **FLUSH**:
  - Pop once per cycle while !stk_empty.
  - When stk_empty: clear err, go to IDLE.
  - clr is ignored in every state other than ERR.

Always true:
- stk_push and stk_pop are never high in the same cycle.
- No push while stk_full; no pop while stk_empty.

## Timing
- Reset values: state=IDLE, tok_ready=1 once out of reset, stk_push=0, stk_pop=0, stk_data_in=0, res_valid=0, res_data=0, err=0, internal b=0.
- Throughput and latency:
  - Operand: 1 cycle per token; back-to-back operands accepted every cycle.
  - Binary operator: 4 cycles from accept to tok_ready high again; the result is pushed on the 4th edge.
  - END: res_valid asserts 2 cycles after the accept edge.
- Error entry: err asserts on the edge after the failing check.
- Reset mid-operation aborts the FSM immediately and drops any in-flight b. This block does not clear the stack; the stack must share rstn at system level.
- stk_full/stk_empty are sampled combinationally in the same cycle as the decision they gate.

## Structure
- Package rpn_pkg:
  - opcode enum (OP_ADD, OP_SUB, OP_MUL, OP_END).
  - state enum (the 8 states above).
  - default WIDTH constant.
- Sub-module rpn_alu: combinational (a, b, op) → WIDTH-bit result.
- The FSM, the b register and the result register stay in rpn_eval.

## Test plan
1. Tokens 3, 4, ADD, END with an empty stack: one res_valid pulse with res_data=7; err=0; stack empty afterwards.
2. Tokens 10, 3, SUB, 2, MUL, END: res_data=14. Then 3, 5, SUB, END: res_data=254 (wrap).
3. WIDTH=8, tokens 16, 16, MUL, END: res_data=0, no error. Tokens 200, 100, ADD, END: res_data=44.
4. Nine operands into a DEPTH=8 stack: the 9th causes err=1 with no push issued; tok_ready=0. Then clr for one cycle: 8 stk_pop cycles, err clears, IDLE.
5. Underflow and leftover operands:
   - 5, ADD: err after the POP_A check, with exactly one pop issued.
   - 1, 2, END (after a flush): err asserts from CHK and res_valid stays 0.
6. rstn low during EXEC: push suppressed, all outputs at reset values; after release, 7, END gives res_data=7.
